dm_shared_port_responder: RTL and testbench
===========================================

Name: dm_shared_port_responder

Overview:
- Memory-side responder for two processor cores' data-memory request interfaces, each using a valid/ready request and valid response handshake.
- Holds one single-port data RAM. Arbitrates the two initiators onto it, one access per cycle, and returns read data or a write acknowledge one cycle after acceptance.
- Zero-fills the RAM after every reset using an internal sweep.
- Sits between core1/core2 and data storage in the multiport processor top, as a lower-cost alternative to a true multiport RAM.

Parameters:
- mem_size, 4096, number of data words; must be a power of 2.
- mem_width, 12, data word width (equals reg_width).
- addr_width, 12, address width; must equal log2(mem_size).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- init_done  out  1  high once the zero-fill sweep has completed.
- req_valid1, req_valid2  in  1  core n presents a request.
- req_ready1, req_ready2  out  1  core n's request is accepted this cycle.
- req_write1, req_write2  in  1  1 = write, 0 = read.
- req_addr1, req_addr2  in  addr_width  word address.
- req_wdata1, req_wdata2  in  mem_width  write data.
- rsp_valid1, rsp_valid2  out  1  one-cycle response pulse.
- rsp_rdata1, rsp_rdata2  out  mem_width  read data; on a write, the data just written.

Behaviour:
- Reset values:
  - init_done = 0, req_ready1/2 = 0, rsp_valid1/2 = 0, rsp_rdata1/2 = 0.
  - Sweep address = 0; round-robin last-grant pointer = port 2, so port 1 wins the first tie.
- FSM states: INIT, RUN.
- INIT:
  - Writes 0 to sweep address each cycle and increments the address.
  - Both ready outputs held 0.
  - After writing address mem_size-1, moves to RUN and sets init_done = 1 on the same edge.
  - Duration is exactly mem_size cycles after reset deasserts.
- RUN:
  - Grant is combinational: req_readyN = grantN, and at most one grant is high per cycle.
  - A request is accepted when req_validN & req_readyN at edge T.
  - Read: RAM output registered; rsp_validN = 1 and rsp_rdataN = mem[addr] during cycle T+1.
  - Write: mem[addr] <= wdata at edge T; rsp_validN = 1 and rsp_rdataN = wdata during T+1.
  - rsp_validN is a single-cycle pulse. rsp_rdataN holds its last value until the next response to port N.
  - The non-granted port's request must remain stable until its ready is seen. The responder does not latch unaccepted requests.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both valid: grant goes to the port not granted last; the pointer updates only on an accepted request.
- Throughput:
  - 1 access per cycle in total.
  - Back-to-back requests from one port with the other idle are accepted every cycle.
  - Under contention, each port is granted every second cycle.
- Same-address cases:
  - Write in cycle T, read of the same address in T+1: the read returns the new data, since the RAM is already updated.
  - A read and a write to the same address cannot be accepted in the same cycle.
- Out-of-range addresses: impossible, because addr_width = log2(mem_size) and addresses wrap naturally.
- Reset mid-operation:
  - Any pending response is dropped, with rsp_valid forced to 0 next cycle.
  - The FSM returns to INIT and the full zero-fill sweep restarts from address 0.
  - The arbitration pointer is reset.
- req_* inputs are ignored while in INIT.

Optional Feature:
- Macro: DM_RR_ARB_EN.
- Defined: round-robin arbitration as described under Behaviour.
- Undefined: fixed priority, port 1 always wins ties, and no pointer register is built. Port 2 can starve if port 1 is held valid continuously.

Decomposition:
- Shared package dm_pkg holds:
  - FSM state typedef (ST_INIT, ST_RUN).
  - Port index constants (PORT1 = 0, PORT2 = 1).
  - DM_PORT_COUNT = 2.
- One sub-module, dm_rr_arbiter: 2-request/2-grant combinational arbiter plus pointer register, with the DM_RR_ARB_EN choice inside it.
- The RAM array and response registers stay in the top module.

Test Plan:
- Reset, then wait: init_done rises exactly 4096 cycles after reset deasserts. Reading addresses 0, 2048 and 4095 then returns 0x000.
- Port 1 writes 0xABC to address 0x010, then reads 0x010 in the next cycle: write rsp_rdata1 = 0xABC at T+1; read rsp_rdata1 = 0xABC at T+2.
- Both ports valid every cycle (port 1 reads 0x100, port 2 reads 0x200, preloaded with 0x111 and 0x222), with DM_RR_ARB_EN defined: grants alternate 1, 2, 1, 2; responses alternate 0x111 and 0x222; 4 accesses in 4 cycles.
- Same contention as above with DM_RR_ARB_EN undefined: req_ready2 stays 0 for 20 cycles and every grant goes to port 1.
- Port 2 issues a read in RUN and reset asserts in the following cycle: rsp_valid2 = 0 in the cycle after reset, init_done = 0, and a read of the previously written address after the new sweep returns 0x000.
- Port 1 writes 0x555 to address 0xFFF while port 2 is idle, then port 2 reads 0xFFF: port 2 receives 0x555 one cycle after acceptance, and port 1 sees no spurious rsp_valid1.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: shared FSM state type and port constants for dm_shared_port_responder
package dm_pkg;
    typedef enum logic {ST_INIT, ST_RUN} st_t;
    localparam int DM_PORT_COUNT = 2;
    localparam int PORT1 = 0;
    localparam int PORT2 = 1;
endpackage

// File: rtl/dm_shared_port_responder_if.sv
// dm_shared_port_responder_if: two-core data-memory request/response bundle
interface dm_shared_port_responder_if #(
    parameter int addr_width = 12,
    parameter int mem_width = 12
);
    logic req_valid1, req_valid2;
    logic req_ready1, req_ready2;
    logic req_write1, req_write2;
    logic [addr_width-1:0] req_addr1, req_addr2;
    logic [mem_width-1:0] req_wdata1, req_wdata2;
    logic rsp_valid1, rsp_valid2;
    logic [mem_width-1:0] rsp_rdata1, rsp_rdata2;
    modport master (
        output req_valid1, req_valid2, req_write1, req_write2,
        output req_addr1, req_addr2, req_wdata1, req_wdata2,
        input req_ready1, req_ready2, rsp_valid1, rsp_valid2, rsp_rdata1, rsp_rdata2
    );
    modport slave (
        input req_valid1, req_valid2, req_write1, req_write2,
        input req_addr1, req_addr2, req_wdata1, req_wdata2,
        output req_ready1, req_ready2, rsp_valid1, rsp_valid2, rsp_rdata1, rsp_rdata2
    );
endinterface

// File: rtl/dm_rr_arbiter.sv
// dm_rr_arbiter: 2-port grant logic; round-robin when DM_RR_ARB_EN is defined, else port 1 fixed priority
module dm_rr_arbiter
    import dm_pkg::*;
(
`ifdef DM_RR_ARB_EN
    input  logic clk,
    input  logic reset,
`endif
    input  logic [DM_PORT_COUNT-1:0] req,
    output logic [DM_PORT_COUNT-1:0] gnt
);
`ifdef DM_RR_ARB_EN
    logic last2;
    // on a tie, grant the port that did not win last time
    always_comb begin
        gnt[PORT1] = req[PORT1] & (!req[PORT2] | last2);
        gnt[PORT2] = req[PORT2] & (!req[PORT1] | !last2);
    end
    // pointer starts at port 2 so port 1 wins the first tie; moves only on a grant
    always_ff @(posedge clk) begin
        if (reset) last2 <= 1'b1;
        else if (|gnt) last2 <= gnt[PORT2];
    end
`else
    // port 1 always wins ties
    always_comb begin
        gnt[PORT1] = req[PORT1];
        gnt[PORT2] = req[PORT2] & !req[PORT1];
    end
`endif
endmodule

// File: rtl/dm_shared_port_responder.sv
// dm_shared_port_responder: single-port data RAM shared by two cores, zero-filled after reset (DM_RR_ARB_EN selects round-robin)
module dm_shared_port_responder
    import dm_pkg::*;
#(
    parameter int mem_size = 4096,
    parameter int mem_width = 12,
    parameter int addr_width = 12
) (
    input  logic clk,
    input  logic reset,
    output logic init_done,
    dm_shared_port_responder_if.slave bus
);
    st_t state, state_nxt;
    logic run;
    logic [addr_width-1:0] sweep, ram_addr;
    logic [mem_width-1:0] mem [mem_size];
    logic [mem_width-1:0] ram_wdata, ram_rdata;
    logic ram_we;
    logic [DM_PORT_COUNT-1:0] req, gnt;

    assign run = state == ST_RUN;
    assign init_done = run;
    assign req = run ? {bus.req_valid2, bus.req_valid1} : '0;
    assign bus.req_ready1 = gnt[PORT1];
    assign bus.req_ready2 = gnt[PORT2];

    dm_rr_arbiter u_arb (
`ifdef DM_RR_ARB_EN
        .clk(clk),
        .reset(reset),
`endif
        .req(req),
        .gnt(gnt)
    );

    // leave the sweep once the last word has been cleared
    always_comb state_nxt = (state == ST_INIT && sweep == addr_width'(mem_size - 1)) ? ST_RUN : state;

    // state register and zero-fill sweep address
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
            sweep <= '0;
        end else begin
            state <= state_nxt;
            sweep <= run ? sweep : sweep + addr_width'(1);
        end
    end

    // single RAM port: sweep owns it in INIT, the granted core in RUN; writes echo their data
    always_comb begin
        ram_addr = !run ? sweep : gnt[PORT1] ? bus.req_addr1 : bus.req_addr2;
        ram_we = !run | (gnt[PORT1] ? bus.req_write1 : gnt[PORT2] & bus.req_write2);
        ram_wdata = !run ? '0 : gnt[PORT1] ? bus.req_wdata1 : bus.req_wdata2;
        ram_rdata = ram_we ? ram_wdata : mem[ram_addr];
    end

    // RAM array write
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    // one-cycle response pulse per accepted request; data holds until the next response
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid1 <= 1'b0;
            bus.rsp_valid2 <= 1'b0;
            bus.rsp_rdata1 <= '0;
            bus.rsp_rdata2 <= '0;
        end else begin
            bus.rsp_valid1 <= gnt[PORT1];
            bus.rsp_valid2 <= gnt[PORT2];
            if (gnt[PORT1]) bus.rsp_rdata1 <= ram_rdata;
            if (gnt[PORT2]) bus.rsp_rdata2 <= ram_rdata;
        end
    end
endmodule

// File: tb/tb_dm_shared_port_responder.sv
// tb_dm_shared_port_responder: directed-vector bench for dm_shared_port_responder
module tb_dm_shared_port_responder;
    logic clk = 1'b0;
    logic reset;
    logic init_done;
    int n_vec = 0;
    int n_bad = 0;

    dm_shared_port_responder_if bus ();

    dm_shared_port_responder dut (
        .clk(clk),
        .reset(reset),
        .init_done(init_done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid1 = 1'b0;
        bus.req_valid2 = 1'b0;
        bus.req_write1 = 1'b0;
        bus.req_write2 = 1'b0;
    endtask

    task automatic wait_init(input string tag);
        int n;
        logic busy;
        n = 0;
        busy = 1'b0;
        reset = 1'b0;
        while (!init_done && n < 6000) begin
            step();
            n++;
            if (!init_done) busy |= bus.req_ready1 | bus.req_ready2 | bus.rsp_valid1 | bus.rsp_valid2;
        end
        idle();
        check({tag, "_cycles"}, n, 4096);
        check({tag, "_quiet"}, busy, 0);
    endtask

    task automatic access(input int p, input logic w, input logic [11:0] a, input logic [11:0] d,
                          input logic [11:0] exp, input string tag);
        if (p == 1) begin
            bus.req_valid1 = 1'b1; bus.req_write1 = w; bus.req_addr1 = a; bus.req_wdata1 = d;
        end else begin
            bus.req_valid2 = 1'b1; bus.req_write2 = w; bus.req_addr2 = a; bus.req_wdata2 = d;
        end
        #1;
        check({tag, "_ready"}, p == 1 ? bus.req_ready1 : bus.req_ready2, 1);
        step();
        idle();
        check({tag, "_valid"}, p == 1 ? bus.rsp_valid1 : bus.rsp_valid2, 1);
        check({tag, "_data"}, p == 1 ? bus.rsp_rdata1 : bus.rsp_rdata2, exp);
        check({tag, "_other"}, p == 1 ? bus.rsp_valid2 : bus.rsp_valid1, 0);
    endtask

    initial begin
        int pulses;
        reset = 1'b1;
        idle();
        bus.req_addr1 = '0; bus.req_addr2 = '0; bus.req_wdata1 = '0; bus.req_wdata2 = '0;
        repeat (3) step();
        check("rst_init_done", init_done, 0);
        check("rst_ready1", bus.req_ready1, 0);
        check("rst_rsp_valid1", bus.rsp_valid1, 0);
        check("rst_rdata1", bus.rsp_rdata1, 0);
        check("rst_rdata2", bus.rsp_rdata2, 0);
        // a request held during the sweep must be ignored
        bus.req_valid1 = 1'b1; bus.req_write1 = 1'b1; bus.req_addr1 = 12'h005; bus.req_wdata1 = 12'h7FF;
        wait_init("init1");

        access(1, 0, 12'h000, 0, 12'h000, "rd_0");
        access(1, 0, 12'h800, 0, 12'h000, "rd_800");
        access(2, 0, 12'hFFF, 0, 12'h000, "rd_fff");
        access(1, 0, 12'h005, 0, 12'h000, "rd_5");

        // write then immediate read of the same word from port 1
        bus.req_valid1 = 1'b1; bus.req_write1 = 1'b1; bus.req_addr1 = 12'h010; bus.req_wdata1 = 12'hABC;
        step();
        check("wr010_valid", bus.rsp_valid1, 1);
        check("wr010_data", bus.rsp_rdata1, 12'hABC);
        bus.req_write1 = 1'b0;
        step();
        idle();
        check("rd010_valid", bus.rsp_valid1, 1);
        check("rd010_data", bus.rsp_rdata1, 12'hABC);

        access(1, 1, 12'h100, 12'h111, 12'h111, "pre100");
        access(2, 1, 12'h200, 12'h222, 12'h222, "pre200");

        // both ports reading every cycle
        bus.req_valid1 = 1'b1; bus.req_addr1 = 12'h100;
        bus.req_valid2 = 1'b1; bus.req_addr2 = 12'h200;
        #1;
        pulses = 0;
`ifdef DM_RR_ARB_EN
        for (int i = 0; i < 4; i++) begin
            check("rr_ready1", bus.req_ready1, i % 2 == 0);
            check("rr_ready2", bus.req_ready2, i % 2 == 1);
            step();
            pulses += int'(bus.rsp_valid1) + int'(bus.rsp_valid2);
            if (i % 2 == 0) begin
                check("rr_rsp1", bus.rsp_valid1, 1);
                check("rr_data1", bus.rsp_rdata1, 12'h111);
            end else begin
                check("rr_rsp2", bus.rsp_valid2, 1);
                check("rr_data2", bus.rsp_rdata2, 12'h222);
            end
        end
        check("rr_accesses", pulses, 4);
`else
        for (int i = 0; i < 20; i++) begin
            check("fp_ready1", bus.req_ready1, 1);
            check("fp_ready2", bus.req_ready2, 0);
            step();
            pulses += int'(bus.rsp_valid1) + 2 * int'(bus.rsp_valid2);
            check("fp_data1", bus.rsp_rdata1, 12'h111);
        end
        check("fp_accesses", pulses, 20);
`endif
        idle();
        step();

        access(1, 1, 12'hFFF, 12'h555, 12'h555, "wr_fff");
        access(2, 0, 12'hFFF, 0, 12'h555, "rd2_fff");

        // reset lands one cycle after a port-2 read is accepted
        access(2, 1, 12'h300, 12'h333, 12'h333, "wr300");
        bus.req_valid2 = 1'b1; bus.req_addr2 = 12'h300;
        #1;
        check("mid_ready2", bus.req_ready2, 1);
        step();
        check("mid_rsp_before", bus.rsp_valid2, 1);
        reset = 1'b1;
        step();
        idle();
        check("mid_rsp_dropped", bus.rsp_valid2, 0);
        check("mid_init_done", init_done, 0);
        check("mid_rdata2", bus.rsp_rdata2, 0);
        wait_init("init2");
        access(2, 0, 12'h300, 0, 12'h000, "post_300");
        access(1, 0, 12'hFFF, 0, 12'h000, "post_fff");
        access(1, 0, 12'h100, 0, 12'h000, "post_100");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
